// File: rtl/orion_types.sv
// Shared core-wide widths and the memory response record carried by the
// DMEM/IMEM responder pipelines.
package orion_types;

    localparam int XLEN   = 32;
    localparam int ADDRW  = 32;
    localparam int BYTE_W = 8;
    localparam int MASKW  = XLEN / BYTE_W;

    typedef struct packed {
        logic            valid;
        logic            err;
        logic [XLEN-1:0] rdata;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_resp_pipe.sv
// Response delay line: shifts dmem_resp_t records through STAGES registers.
// Latency: STAGES cycles from head to tail.
// Backpressure: none; a record enters every cycle and the consumer must take it.
module dmem_resp_pipe
    import orion_types::*;
#(
    parameter int STAGES = 1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  dmem_resp_t head,
    output dmem_resp_t tail
);

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] err_q;
    logic [XLEN-1:0]   dat_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
            err_q <= '0;
        end else begin
            vld_q[0] <= head.valid;
            err_q[0] <= head.err;
            for (int s = 1; s < STAGES; s++) begin
                vld_q[s] <= vld_q[s-1];
                err_q[s] <= err_q[s-1];
            end
        end
    end

    // Data only moves alongside a valid load so the tail keeps its last word.
    always_ff @(posedge clk_i) begin
        if (head.valid) begin
            dat_q[0] <= head.rdata;
        end
        for (int s = 1; s < STAGES; s++) begin
            if (vld_q[s-1]) begin
                dat_q[s] <= dat_q[s-1];
            end
        end
    end

    assign tail.valid = vld_q[STAGES-1];
    assign tail.err   = err_q[STAGES-1];
    assign tail.rdata = dat_q[STAGES-1];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: byte-masked word SRAM with a fixed-latency load response.
// Latency: RD_LATENCY cycles from request to rvalid/err strobe.
// Backpressure: none; one request accepted every cycle, responses cannot stall.
module dmem_responder
    import orion_types::*;
#(
    parameter int               DEPTH_WORDS = 1024,
    parameter logic [ADDRW-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int               RD_LATENCY  = 1,
    parameter string            INIT_FILE   = ""
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             dmem_valid_i,
    input  logic [ADDRW-1:0] dmem_addr_i,
    input  logic [MASKW-1:0] dmem_mask_i,
    input  logic [XLEN-1:0]  dmem_wdata_i,
    input  logic             dmem_we_i,
    output logic             dmem_rvalid_o,
    output logic [XLEN-1:0]  dmem_rdata_o,
    output logic             dmem_err_o
);

    localparam int IDXW = $clog2(DEPTH_WORDS);

    // One extra bit so a window ending at the top of the address space does not wrap.
    localparam logic [ADDRW:0] BASE_EXT  = {1'b0, BASE_ADDR};
    localparam logic [ADDRW:0] LIMIT_EXT = BASE_EXT + (ADDRW+1)'(4 * DEPTH_WORDS);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    logic [ADDRW:0]  addr_ext;
    logic            in_range;
    logic [IDXW-1:0] idx;
    logic            wr_en;
    logic            unused_addr_lsb;
    dmem_resp_t      resp_head;
    dmem_resp_t      resp_tail;
    logic [XLEN-1:0] rdata_hold;

    assign addr_ext        = {1'b0, dmem_addr_i};
    assign in_range        = (addr_ext >= BASE_EXT) && (addr_ext < LIMIT_EXT);
    // BASE_ADDR is aligned to the window size, so the low address bits are the word index.
    assign idx             = dmem_addr_i[IDXW+1:2];
    assign unused_addr_lsb = ^dmem_addr_i[1:0];
    assign wr_en           = dmem_valid_i && dmem_we_i && in_range;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int i = 0; i < MASKW; i++) begin
                if (dmem_mask_i[i]) begin
                    mem[idx][BYTE_W*i +: BYTE_W] <= dmem_wdata_i[BYTE_W*i +: BYTE_W];
                end
            end
        end
    end

    assign resp_head.valid = dmem_valid_i && !dmem_we_i;
    assign resp_head.err   = dmem_valid_i && !in_range;
    assign resp_head.rdata = in_range ? mem[idx] : '0;

    dmem_resp_pipe #(
        .STAGES (RD_LATENCY)
    ) u_resp_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .head  (resp_head),
        .tail  (resp_tail)
    );

    // Pipeline data is not reset, so a reset-cleared hold register covers idle cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_hold <= '0;
        end else if (resp_tail.valid) begin
            rdata_hold <= resp_tail.rdata;
        end
    end

    assign dmem_rvalid_o = resp_tail.valid;
    assign dmem_err_o    = resp_tail.err;
    assign dmem_rdata_o  = resp_tail.valid ? resp_tail.rdata : rdata_hold;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (RD_LATENCY >= 1 && RD_LATENCY <= 4)
                else $error("dmem_responder: RD_LATENCY out of range");
            assert ((DEPTH_WORDS & (DEPTH_WORDS - 1)) == 0)
                else $error("dmem_responder: DEPTH_WORDS not a power of two");
            assert (!dmem_valid_i ||
                    !$isunknown({dmem_addr_i, dmem_mask_i, dmem_wdata_i, dmem_we_i}))
                else $error("dmem_responder: unknown request fields");
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with RD_LATENCY = 2, DEPTH_WORDS = 1024, BASE 0.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dmem_valid = 1'b0;
    logic [31:0] dmem_addr  = '0;
    logic [3:0]  dmem_mask  = '0;
    logic [31:0] dmem_wdata = '0;
    logic        dmem_we    = 1'b0;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        dmem_err;

    int n_checks = 0;
    int n_pass   = 0;

    logic [33:0] obs;
    logic [33:0] exp_v;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .BASE_ADDR   (32'h0000_0000),
        .RD_LATENCY  (LAT),
        .INIT_FILE   ("")
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .dmem_valid_i  (dmem_valid),
        .dmem_addr_i   (dmem_addr),
        .dmem_mask_i   (dmem_mask),
        .dmem_wdata_i  (dmem_wdata),
        .dmem_we_i     (dmem_we),
        .dmem_rvalid_o (dmem_rvalid),
        .dmem_rdata_o  (dmem_rdata),
        .dmem_err_o    (dmem_err)
    );

    // Observed outputs packed as {rvalid, err, rdata}.
    assign obs = {dmem_rvalid, dmem_err, dmem_rdata};

    task automatic drive_req(input logic we, input logic [31:0] a,
                             input logic [3:0] m, input logic [31:0] d);
        dmem_valid = 1'b1;
        dmem_we    = we;
        dmem_addr  = a;
        dmem_mask  = m;
        dmem_wdata = d;
    endtask

    task automatic drive_idle();
        dmem_valid = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_mask  = '0;
        dmem_wdata = '0;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        drive_req(1'b1, a, m, d);
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp_v = {1'b0, 1'b0, 32'h0};
            n_checks++;
            if (obs !== exp_v) $display("FAIL reset_idle[%0d]: got %h want %h", i, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_full_word();
        do_store(32'h10, 4'b1111, 32'hDEAD_BEEF);
        drive_req(1'b0, 32'h10, 4'b0, 32'h0);
        @(negedge clk);
        drive_idle();
        exp_v = {1'b0, 1'b0, 32'h0};
        n_checks++;
        if (obs !== exp_v) $display("FAIL full_word_early: got %h want %h", obs, exp_v);
        else n_pass++;
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 32'hDEAD_BEEF};
        n_checks++;
        if (obs !== exp_v) $display("FAIL full_word_resp: got %h want %h", obs, exp_v);
        else n_pass++;
        @(negedge clk);
        exp_v = {1'b0, 1'b0, 32'hDEAD_BEEF};
        n_checks++;
        if (obs !== exp_v) $display("FAIL full_word_hold: got %h want %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_byte_mask();
        logic [3:0]  masks [3];
        logic [31:0] wdat  [3];
        logic [31:0] want  [3];
        masks = '{4'b0001, 4'b1100, 4'b0000};
        wdat  = '{32'h0000_00AA, 32'h5566_0000, 32'hFFFF_FFFF};
        want  = '{32'h1122_33AA, 32'h5566_33AA, 32'h5566_33AA};
        do_store(32'h20, 4'b1111, 32'h1122_3344);
        for (int k = 0; k < 3; k++) begin
            do_store(32'h20, masks[k], wdat[k]);
            drive_req(1'b0, 32'h20, 4'b0, 32'h0);
            @(negedge clk);
            drive_idle();
            @(negedge clk);
            exp_v = {1'b1, 1'b0, want[k]};
            n_checks++;
            if (obs !== exp_v) $display("FAIL byte_mask[%0d]: got %h want %h", k, obs, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [3];
        want = '{32'hCAFE_0000, 32'hCAFE_0004, 32'hCAFE_0008};
        for (int k = 0; k < 3; k++) do_store(32'(4 * k), 4'b1111, want[k]);
        for (int c = 0; c < 6; c++) begin
            if (c >= LAT && c < LAT + 3) begin
                exp_v = {1'b1, 1'b0, want[c-LAT]};
                n_checks++;
                if (obs !== exp_v) $display("FAIL b2b_resp[%0d]: got %h want %h", c - LAT, obs, exp_v);
                else n_pass++;
            end else if (c == LAT + 3) begin
                exp_v = {1'b0, 1'b0, want[2]};
                n_checks++;
                if (obs !== exp_v) $display("FAIL b2b_after: got %h want %h", obs, exp_v);
                else n_pass++;
            end
            if (c < 3) drive_req(1'b0, 32'(4 * c), 4'b0, 32'h0);
            else drive_idle();
            @(negedge clk);
        end
    endtask

    task automatic test_boundary();
        do_store(32'hFFC, 4'b1111, 32'h7654_3210);
        drive_req(1'b0, 32'hFFC, 4'b0, 32'h0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 32'h7654_3210};
        n_checks++;
        if (obs !== exp_v) $display("FAIL last_word: got %h want %h", obs, exp_v);
        else n_pass++;

        drive_req(1'b0, 32'h1000, 4'b0, 32'h0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        exp_v = {1'b1, 1'b1, 32'h0};
        n_checks++;
        if (obs !== exp_v) $display("FAIL oor_load: got %h want %h", obs, exp_v);
        else n_pass++;
        @(negedge clk);
        exp_v = {1'b0, 1'b0, 32'h0};
        n_checks++;
        if (obs !== exp_v) $display("FAIL oor_load_after: got %h want %h", obs, exp_v);
        else n_pass++;

        drive_req(1'b1, 32'h1000, 4'b1111, 32'hFFFF_FFFF);
        @(negedge clk);
        drive_idle();
        exp_v = {1'b0, 1'b0, 32'h0};
        n_checks++;
        if (obs !== exp_v) $display("FAIL oor_store_early: got %h want %h", obs, exp_v);
        else n_pass++;
        @(negedge clk);
        exp_v = {1'b0, 1'b1, 32'h0};
        n_checks++;
        if (obs !== exp_v) $display("FAIL oor_store_err: got %h want %h", obs, exp_v);
        else n_pass++;

        // Word 0 shares its index with the out-of-range address and must be untouched.
        drive_req(1'b0, 32'h0, 4'b0, 32'h0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 32'hCAFE_0000};
        n_checks++;
        if (obs !== exp_v) $display("FAIL oor_store_unchanged: got %h want %h", obs, exp_v);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive_req(1'b0, 32'h10, 4'b0, 32'h0);
        @(negedge clk);
        drive_idle();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) rst = 1'b0;
            exp_v = {1'b0, 1'b0, 32'h0};
            n_checks++;
            if (obs !== exp_v) $display("FAIL reset_mid[%0d]: got %h want %h", i, obs, exp_v);
            else n_pass++;
        end
        drive_req(1'b0, 32'h10, 4'b0, 32'h0);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        exp_v = {1'b1, 1'b0, 32'hDEAD_BEEF};
        n_checks++;
        if (obs !== exp_v) $display("FAIL reset_preserve: got %h want %h", obs, exp_v);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_byte_mask();
        test_back_to_back();
        test_boundary();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
